// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types_pkg
// Description : Shared bus widths, word type and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types_pkg;

    localparam int RAM_ADDR_SIZE = 32;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/generic_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : generic_bus_if
// Description : Simple request/busy memory bus; generic_bus = slave side,
//               cpu = master side.
// Revision    : 1.0 - initial release
// ============================================================================
interface generic_bus_if;
    import rv32i_types_pkg::*;

    logic                     ren;
    logic                     wen;
    logic [RAM_ADDR_SIZE-1:0] addr;
    word_t                    wdata;
    logic [3:0]               byte_en;
    word_t                    rdata;
    logic                     busy;
    logic                     error;

    modport generic_bus (
        input  ren, wen, addr, wdata, byte_en,
        output rdata, busy, error
    );

    modport cpu (
        output ren, wen, addr, wdata, byte_en,
        input  rdata, busy, error
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_watchdog
// Description : Stall counter for a granted transaction; expire fires on the
//               WATCHDOG_CYCLES-th stalled grant cycle (0 disables it).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog #(
    parameter int WATCHDOG_CYCLES = 256
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    input  logic busy,
    output logic expire
);

    generate
        if (WATCHDOG_CYCLES == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            localparam int                 c_CNT_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
            localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(WATCHDOG_CYCLES - 1);

            logic [c_CNT_W-1:0] r_count;

            // Saturates at the limit so a long stall can never wrap past it.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable && busy && (r_count != c_LIMIT)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign expire = enable && busy && (r_count == c_LIMIT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requestor (instruction/data) arbiter onto one RAM port,
//               with stall watchdog. Define MEM_ARB_RR_EN for round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 256
) (
    input  logic                    CLK,
    input  logic                    nRST,
    generic_bus_if.generic_bus      i_bus,
    generic_bus_if.generic_bus      d_bus,
    generic_bus_if.cpu              out_bus
);

    arb_state_t r_state;
    logic       w_d_req;
    logic       w_i_req;
    logic       w_gnt_req;
    logic       w_pick_d;
    logic       w_done;
    logic       w_expire;
    logic       w_wd_clear;
    logic       w_wd_enable;

    assign w_d_req   = d_bus.ren | d_bus.wen;
    assign w_i_req   = i_bus.ren | i_bus.wen;
    assign w_gnt_req = (r_state == GRANT_D) ? w_d_req :
                       (r_state == GRANT_I) ? w_i_req : 1'b0;
    assign w_done    = w_gnt_req & ~out_bus.busy;

`ifdef MEM_ARB_RR_EN
    logic r_last_d;
    logic w_other_req;
    assign w_pick_d    = w_d_req & (~w_i_req | ~r_last_d);
    assign w_other_req = (r_state == GRANT_D) ? w_i_req : w_d_req;
`else
    assign w_pick_d    = w_d_req;
`endif

    // Count restarts in IDLE and at every completion, covering direct switches.
    assign w_wd_clear  = (r_state == IDLE) | w_done;
    assign w_wd_enable = w_gnt_req;

    mem_arb_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_watchdog (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (w_wd_clear),
        .enable (w_wd_enable),
        .busy   (out_bus.busy),
        .expire (w_expire)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
`ifdef MEM_ARB_RR_EN
            r_last_d <= 1'b1;
`endif
        end else begin
`ifdef MEM_ARB_RR_EN
            if (r_state == GRANT_D) begin
                r_last_d <= 1'b1;
            end else if (r_state == GRANT_I) begin
                r_last_d <= 1'b0;
            end
`endif
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state <= GRANT_D;
                    end else if (w_i_req) begin
                        r_state <= GRANT_I;
                    end
                end
                GRANT_D, GRANT_I: begin
                    if (!w_gnt_req || w_expire) begin
                        r_state <= IDLE;
                    end else if (w_done) begin
`ifdef MEM_ARB_RR_EN
                        if (w_other_req) begin
                            r_state <= (r_state == GRANT_D) ? GRANT_I : GRANT_D;
                        end else begin
                            r_state <= IDLE;
                        end
`else
                        r_state <= IDLE;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_bus.ren     = 1'b0;
        out_bus.wen     = 1'b0;
        out_bus.addr    = '0;
        out_bus.wdata   = '0;
        out_bus.byte_en = '0;
        d_bus.rdata     = '0;
        d_bus.busy      = 1'b1;
        d_bus.error     = 1'b0;
        i_bus.rdata     = '0;
        i_bus.busy      = 1'b1;
        i_bus.error     = 1'b0;
        case (r_state)
            GRANT_D: begin
                out_bus.ren     = d_bus.ren & ~w_expire;
                out_bus.wen     = d_bus.wen & ~w_expire;
                out_bus.addr    = d_bus.addr;
                out_bus.wdata   = d_bus.wdata;
                out_bus.byte_en = d_bus.byte_en;
                d_bus.rdata     = out_bus.rdata;
                d_bus.busy      = out_bus.busy & ~w_expire;
                d_bus.error     = out_bus.error | w_expire;
            end
            GRANT_I: begin
                out_bus.ren     = i_bus.ren & ~w_expire;
                out_bus.wen     = i_bus.wen & ~w_expire;
                out_bus.addr    = i_bus.addr;
                out_bus.wdata   = i_bus.wdata;
                out_bus.byte_en = i_bus.byte_en;
                i_bus.rdata     = out_bus.rdata;
                i_bus.busy      = out_bus.busy & ~w_expire;
                i_bus.error     = out_bus.error | w_expire;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a latency-programmable
//               RAM model and a transaction-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int WD = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic CLK;
    logic nRST;

    generic_bus_if i_bus ();
    generic_bus_if d_bus ();
    generic_bus_if out_bus ();

    mem_arbiter #(
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_bus   (i_bus),
        .d_bus   (d_bus),
        .out_bus (out_bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur_cyc = 0;
    bit          model_last_d = 1'b1;

    logic        s_use_d = 1'b0;
    logic        s_use_i = 1'b0;
    logic        s_d_wr = 1'b0;
    logic [31:0] s_d_addr = 32'hFFFF_FFF0;
    logic [31:0] s_i_addr = 32'hFFFF_FFE0;
    logic [31:0] s_d_wdata = '0;
    logic [3:0]  s_d_be = '0;
    logic [31:0] s_d_rdat = '0;
    logic [31:0] s_i_rdat = '0;
    logic        s_d_err = 1'b0;
    logic        s_i_err = 1'b0;
    int          s_d_lat = 1;
    int          s_i_lat = 1;

    // RAM: answers after a per-address number of busy cycles.
    int          ram_cnt = 0;
    int          ram_lat;
    logic [31:0] ram_dat;
    logic        ram_err;

    always_comb begin
        ram_lat = 1;
        ram_dat = '0;
        ram_err = 1'b0;
        if (out_bus.addr == s_d_addr) begin
            ram_lat = s_d_lat;
            ram_dat = s_d_rdat;
            ram_err = s_d_err;
        end else if (out_bus.addr == s_i_addr) begin
            ram_lat = s_i_lat;
            ram_dat = s_i_rdat;
            ram_err = s_i_err;
        end
    end

    assign out_bus.busy  = (ram_cnt != ram_lat);
    assign out_bus.rdata = (ram_cnt == ram_lat) ? ram_dat : 32'h0;
    assign out_bus.error = (ram_cnt == ram_lat) ? ram_err : 1'b0;

    always @(posedge CLK) begin
        if ((out_bus.ren || out_bus.wen) && out_bus.busy) ram_cnt <= ram_cnt + 1;
        else                                              ram_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_cyc, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_ren"},   out_bus.ren, 0);
        check({tag, "_out_wen"},   out_bus.wen, 0);
        check({tag, "_out_addr"},  out_bus.addr, 0);
        check({tag, "_out_wdata"}, out_bus.wdata, 0);
        check({tag, "_out_be"},    out_bus.byte_en, 0);
        check({tag, "_d_busy"},    d_bus.busy, 1);
        check({tag, "_d_error"},   d_bus.error, 0);
        check({tag, "_d_rdata"},   d_bus.rdata, 0);
        check({tag, "_i_busy"},    i_bus.busy, 1);
        check({tag, "_i_error"},   i_bus.error, 0);
        check({tag, "_i_rdata"},   i_bus.rdata, 0);
    endtask

    // Cycles a transaction holds the grant, including its completion cycle.
    function automatic int len_of(input int lat);
        return (lat + 1 < WD) ? lat + 1 : WD;
    endfunction

    // Starts in a cycle where the arbiter is idle; cycle 1 is the first grant cycle.
    task automatic run_scn();
        int  sd, ed, si, ei, e1, s2, e2, l1, l2, last;
        bit  first_d, ab1, ab_d, ab_i, d_done, i_done, in_d, in_i;
        logic exp_ren, exp_wen;
        sd = -10; ed = -10; si = -10; ei = -10;
        first_d = s_use_d && (!s_use_i || !RR || !model_last_d);
        l1  = first_d ? s_d_lat : s_i_lat;
        e1  = len_of(l1);
        ab1 = (l1 >= WD);
        if (first_d) begin sd = 1; ed = e1; end
        else         begin si = 1; ei = e1; end
        if (s_use_d && s_use_i) begin
            l2 = first_d ? s_i_lat : s_d_lat;
            s2 = e1 + ((RR && !ab1) ? 1 : 2);
            e2 = s2 + len_of(l2) - 1;
            if (first_d) begin si = s2; ei = e2; end
            else         begin sd = s2; ed = e2; end
            model_last_d = !first_d;
        end else begin
            model_last_d = first_d;
        end
        last = ((ed > ei) ? ed : ei) + 1;
        ab_d = (s_d_lat >= WD);
        ab_i = (s_i_lat >= WD);

        if (s_use_d) begin
            d_bus.ren     = !s_d_wr;
            d_bus.wen     = s_d_wr;
            d_bus.addr    = s_d_addr;
            d_bus.wdata   = s_d_wdata;
            d_bus.byte_en = s_d_be;
        end
        if (s_use_i) begin
            i_bus.ren  = 1'b1;
            i_bus.addr = s_i_addr;
        end

        for (int c = 1; c <= last; c++) begin
            @(posedge CLK);
            #1;
            if (c == ed + 1) begin d_bus.ren = 1'b0; d_bus.wen = 1'b0; end
            if (c == ei + 1) i_bus.ren = 1'b0;
            @(negedge CLK);
            cur_cyc = c;
            d_done = (c == ed);
            i_done = (c == ei);
            check("d_busy",  d_bus.busy,  !d_done);
            check("d_error", d_bus.error, d_done && (ab_d || s_d_err));
            check("d_rdata", d_bus.rdata, (d_done && !ab_d) ? s_d_rdat : 32'h0);
            check("i_busy",  i_bus.busy,  !i_done);
            check("i_error", i_bus.error, i_done && (ab_i || s_i_err));
            check("i_rdata", i_bus.rdata, (i_done && !ab_i) ? s_i_rdat : 32'h0);
            in_d = (c >= sd) && (c <= ed);
            in_i = (c >= si) && (c <= ei);
            exp_ren = 1'b0;
            exp_wen = 1'b0;
            if (in_d) begin
                exp_ren = !s_d_wr && !(d_done && ab_d);
                exp_wen =  s_d_wr && !(d_done && ab_d);
                check("out_addr_d",  out_bus.addr,    s_d_addr);
                check("out_wdata_d", out_bus.wdata,   s_d_wdata);
                check("out_be_d",    out_bus.byte_en, s_d_be);
            end else if (in_i) begin
                exp_ren = !(i_done && ab_i);
                check("out_addr_i",  out_bus.addr,    s_i_addr);
            end
            check("out_ren", out_bus.ren, exp_ren);
            check("out_wen", out_bus.wen, exp_wen);
        end
    endtask

    initial begin
        nRST          = 1'b0;
        d_bus.ren     = 1'b0;
        d_bus.wen     = 1'b0;
        d_bus.addr    = '0;
        d_bus.wdata   = '0;
        d_bus.byte_en = '0;
        i_bus.ren     = 1'b0;
        i_bus.wen     = 1'b0;
        i_bus.addr    = '0;
        i_bus.wdata   = '0;
        i_bus.byte_en = '0;

        repeat (2) @(posedge CLK);
        #1;
        check_reset("reset");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Simultaneous i read @0x0 and d write @0x40; last grant is data after reset.
        s_use_d = 1; s_use_i = 1; s_d_wr = 1;
        s_d_addr = 32'h40; s_d_wdata = 32'h1234_5678; s_d_be = 4'hF;
        s_i_addr = 32'h0;  s_d_rdat = 32'h0; s_i_rdat = 32'hCAFE_0001;
        s_d_err = 0; s_i_err = 0; s_d_lat = 2; s_i_lat = 1;
        run_scn();

        // d read @0x100, three busy cycles, DEADBEEF returned.
        s_use_d = 1; s_use_i = 0; s_d_wr = 0;
        s_d_addr = 32'h100; s_i_addr = 32'h1100; s_d_rdat = 32'hDEAD_BEEF;
        s_d_wdata = 32'h0; s_d_be = 4'h0; s_d_lat = 3;
        run_scn();

        // RAM stuck busy: watchdog abort on the WD-th grant cycle.
        s_d_addr = 32'h800; s_i_addr = 32'h1800; s_d_lat = 20;
        run_scn();

        // Granted i drops its request after one grant cycle.
        s_use_d = 0; s_use_i = 0;
        s_i_addr = 32'h200; s_d_addr = 32'h300; s_i_lat = 5; s_i_err = 0;
        i_bus.addr = s_i_addr;
        i_bus.ren  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cur_cyc = 1;
        check("drop_gnt_ren",  out_bus.ren, 1);
        check("drop_gnt_addr", out_bus.addr, s_i_addr);
        @(posedge CLK);
        #1;
        i_bus.ren = 1'b0;
        #1;
        cur_cyc = 2;
        check("drop_out_ren", out_bus.ren, 0);
        check("drop_i_error", i_bus.error, 0);
        model_last_d = 1'b0;
        @(posedge CLK);
        #1;
        s_use_d = 1; s_d_wr = 0; s_d_lat = 2; s_d_rdat = 32'h5555_AAAA; s_d_err = 0;
        run_scn();

        for (int k = 0; k < 24; k++) begin
            int sel;
            sel       = $urandom_range(1, 3);
            s_use_d   = sel[0];
            s_use_i   = sel[1];
            s_d_wr    = $urandom_range(0, 1) == 1;
            s_d_addr  = $urandom & 32'hFFFF_EFFC;
            s_i_addr  = s_d_addr ^ 32'h0000_1000;
            s_d_wdata = $urandom;
            s_d_be    = 4'($urandom_range(0, 15));
            s_d_rdat  = $urandom;
            s_i_rdat  = $urandom;
            s_d_err   = $urandom_range(0, 3) == 0;
            s_i_err   = $urandom_range(0, 3) == 0;
            s_d_lat   = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(0, 5);
            s_i_lat   = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(0, 5);
            run_scn();
        end

        // Reset pulsed mid-transaction, between clock edges.
        s_d_addr = 32'h500; s_i_addr = 32'h1500; s_d_lat = 4; s_d_err = 0;
        d_bus.addr = s_d_addr;
        d_bus.wen  = 1'b0;
        d_bus.ren  = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        cur_cyc = 0;
        check_reset("async_rst");
        d_bus.ren = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        model_last_d = 1'b1;
        @(posedge CLK);
        #1;

        s_use_d = 1; s_use_i = 0; s_d_wr = 0;
        s_d_addr = 32'h100; s_i_addr = 32'h1100; s_d_rdat = 32'h0BAD_F00D; s_d_lat = 2;
        run_scn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
